// File: rtl/matmul_pkg.sv
// Shared types and helpers for the resource-shared matrix-multiply sequencer.
package matmul_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StLast,
    StOut,
    StFin
  } mm_state_e;

  // Address/counter width that never collapses to zero bits.
  function automatic int unsigned addr_width(input int unsigned x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Signed multiply-accumulate with a registered, sign-extended accumulator.
module mac_unit #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 34
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [ACC_W-1:0]  acc_o
);

  logic signed [2*DATA_W-1:0] prod;
  logic        [ACC_W-1:0]    prod_ext;
  logic        [ACC_W-1:0]    acc_d, acc_q;

  assign prod     = $signed(a_i) * $signed(b_i);
  assign prod_ext = {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};

  // Clear has priority; the sequencer never asserts both in the same cycle.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + prod_ext;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/matmul_sequencer.sv
// C = A*B computed one element at a time through a single shared MAC,
// with operand read scheduling and a valid/ready result port.
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int unsigned M      = 2,
  parameter int unsigned N      = 2,
  parameter int unsigned P      = 2,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 2*DATA_W + $clog2(N) + 1,
  localparam int unsigned AA_W  = addr_width(M*N),
  localparam int unsigned BA_W  = addr_width(N*P),
  localparam int unsigned CA_W  = addr_width(M*P)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rd_en_o,
  output logic [AA_W-1:0]   a_addr_o,
  output logic [BA_W-1:0]   b_addr_o,
  input  logic [DATA_W-1:0] a_data_i,
  input  logic [DATA_W-1:0] b_data_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [CA_W-1:0]   res_addr_o,
  output logic [ACC_W-1:0]  res_data_o
);

  localparam int unsigned IW = addr_width(M);
  localparam int unsigned JW = addr_width(P);
  localparam int unsigned KW = addr_width(N);

  mm_state_e     state_d, state_q;
  logic [IW-1:0] i_d, i_q;
  logic [JW-1:0] j_d, j_q;
  logic [KW-1:0] k_d, k_q;
  logic          dvalid_q;
  logic          acc_clr;
  logic          rd_en;

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    acc_clr     = 1'b0;
    rd_en       = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    res_valid_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StIssue;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_clr = 1'b1;
        end
      end
      StIssue: begin
        busy_o = 1'b1;
        rd_en  = 1'b1;
        if (k_q == KW'(N - 1)) begin
          state_d = StLast;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      // Last operand pair lands this cycle; no new reads.
      StLast: begin
        busy_o  = 1'b1;
        state_d = StOut;
      end
      StOut: begin
        busy_o      = 1'b1;
        res_valid_o = 1'b1;
        if (res_ready_i) begin
          if (i_q == IW'(M - 1) && j_q == JW'(P - 1)) begin
            state_d = StFin;
          end else begin
            state_d = StIssue;
            k_d     = '0;
            acc_clr = 1'b1;
            if (j_q == JW'(P - 1)) begin
              j_d = '0;
              i_d = i_q + IW'(1);
            end else begin
              j_d = j_q + JW'(1);
            end
          end
        end
      end
      StFin: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      dvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      dvalid_q <= rd_en;
    end
  end

  assign rd_en_o    = rd_en;
  assign a_addr_o   = AA_W'(32'(i_q) * N + 32'(k_q));
  assign b_addr_o   = BA_W'(32'(k_q) * P + 32'(j_q));
  assign res_addr_o = CA_W'(32'(i_q) * P + 32'(j_q));

  mac_unit #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (acc_clr),
    .en_i  (dvalid_q),
    .a_i   (a_data_i),
    .b_i   (b_data_i),
    .acc_o (res_data_o)
  );

endmodule

// File: doc/matmul_sequencer.md
# matmul_sequencer

Sequences a matrix product C = A·B through a single multiply-accumulate datapath, one output element at a time. It sits between two read-only operand memories (A row-major M×N, B row-major N×P) and a result consumer. It issues operand read addresses, accumulates N products per element and presents each result with a valid/ready handshake. It replaces the fully unrolled combinational dot product with a resource-shared, cycle-scheduled engine of one multiplier and one adder.

## Interface
- M, 2, rows of A and of C
- N, 2, columns of A, rows of B (dot-product length), ≥1
- P, 2, columns of B and of C
- DATA_W, 16, signed operand width
- ACC_W, 2*DATA_W+$clog2(N)+1, signed accumulator/result width
- AA_W / BA_W / CA_W (localparams): max(1,$clog2(M*N)) / max(1,$clog2(N*P)) / max(1,$clog2(M*P))

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; low forces all state to reset values
- start  in  1  one-cycle request; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last result handshake
- rd_en  out  1  read strobe for both operand memories
- a_addr  out  AA_W  i*N+k
- b_addr  out  BA_W  k*P+j
- a_data  in  DATA_W  A operand, valid exactly 1 cycle after rd_en
- b_data  in  DATA_W  B operand, valid exactly 1 cycle after rd_en
- res_valid  out  1  result present
- res_ready  in  1  consumer accepts when res_valid && res_ready
- res_addr  out  CA_W  i*P+j
- res_data  out  ACC_W  C[i][j]

## Operation
- FSM states: IDLE, ISSUE, LAST, OUT, FIN.
- IDLE → ISSUE on start; i, j, k cleared, acc cleared.
- ISSUE: rd_en=1 with the current (i,k,j) addresses; k increments each cycle; after issuing k=N-1 → LAST.
- Accumulation: dvalid = rd_en delayed one cycle; when dvalid, acc += a_data*b_data (full 2*DATA_W product, sign-extended to ACC_W).
- LAST: rd_en=0; the final product is accumulated → OUT.
- OUT: res_valid=1; res_data=acc, res_addr=i*P+j, both held stable until the handshake.
  - On handshake: if i=M-1 and j=P-1 → FIN.
  - Otherwise advance j (wrapping to 0 and incrementing i), clear k and acc → ISSUE.
- FIN: done=1 for one cycle → IDLE.
- Results are emitted in row-major order (res_addr 0..M*P-1).
- Arithmetic is two's complement and wraps modulo 2^ACC_W; no saturation and no overflow flag.
- start outside IDLE is ignored. No abort input; reset is the only abort.

## Timing
- Reset values: busy=0, done=0, rd_en=0, res_valid=0; all addresses, res_data and acc are 0; state IDLE.
- Start accepted at edge t; the first ISSUE cycle is t+1 (busy=1, rd_en=1, a_addr=0, b_addr=0).
- Per element with res_ready held high: N ISSUE + 1 LAST + 1 OUT = N+2 cycles.
- With res_ready held high, done is asserted in cycle t+1+M*P*(N+2) and busy drops in the same cycle as done. done is not asserted in IDLE.
- Backpressure: OUT waits indefinitely and issues no reads while waiting.
- N=1: ISSUE lasts one cycle; the element takes 3 cycles.
- Asynchronous reset mid-operation: everything returns immediately to reset values. The in-flight result is lost, no done is generated, and the next start begins again from element 0.

## Structure
- Shared package matmul_pkg holds:
  - the state enum (IDLE, ISSUE, LAST, OUT, FIN)
  - an addr_width helper function (max(1,$clog2(x)))
- Sub-module mac_unit (DATA_W, ACC_W) is natural: registered accumulator with clear and enable inputs (dvalid), signed multiply, sign extension.
- The sequencer holds the FSM, the i/j/k counters and the address generation.

## Test plan
- 2×2×2, A=[1,2,3,4], B=[5,6,7,8], res_ready=1 → results 19,22,43,50 at res_addr 0..3; done exactly 17 cycles after the start-accept edge.
- Signed operands, DATA_W=8, A=[-128,127], B=[-128,-1] (M=1,N=2,P=1) → single result 16384-127=16257.
- Backpressure: res_ready low for 5 cycles on each result → res_valid/res_data/res_addr stable; rd_en=0 while stalled; values identical to the first test.
- N=1, M=3, P=2 → 6 results of a_i*b_j, 3 cycles per element; done at 19.
- start pulsed during ISSUE and again during OUT → ignored; exactly one result sequence and one done pulse.
- reset driven low mid-ISSUE of element 2 → all outputs 0 immediately. After release, a fresh start produces the full correct sequence from res_addr 0.
